// File: rtl/aes_wb_master_if.sv
// Wishbone classic single-initiator bus bundle used between aes_wb_master and the AES128 peripheral.
interface aes_wb_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/aes_wb_master.sv
// Wishbone sequencer: programs the AES128 peripheral, polls for done and reads back the ciphertext.
// Optional poll-limit / ack-watchdog error path enabled by AES_WB_MASTER_TIMEOUT_EN.
module aes_wb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned POLL_GAP  = 4
`ifdef AES_WB_MASTER_TIMEOUT_EN
  , parameter int unsigned MAX_POLLS = 256
`endif
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic [127:0]          key_i,
  input  logic [127:0]          text_i,
  output logic                  busy_o,
  output logic [127:0]          result_o,
  output logic                  result_valid_o,
`ifdef AES_WB_MASTER_TIMEOUT_EN
  output logic                  error_o,
`endif
  aes_wb_master_if.master       wbm
);

  localparam int unsigned     GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
`ifdef AES_WB_MASTER_TIMEOUT_EN
  localparam int unsigned       POLL_W    = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);
  localparam logic [15:0]       WDOG_LAST = 16'hFFFE;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_ENA, S_WKEY, S_WTXT, S_LOAD, S_RUN, S_POLL, S_GAP, S_RD, S_DONE, S_ERR
  } state_e;

  state_e             state_q, nxt_state_d;
  logic [1:0]         beat_q, nxt_beat_d;
  logic [GAP_W-1:0]   gap_q;
  logic               stb_q, we_q;
  logic [31:0]        adr_q, dat_q;
  logic [127:0]       key_q, text_q, result_q;
  logic               valid_q, busy_q;
`ifdef AES_WB_MASTER_TIMEOUT_EN
  logic               error_q;
  logic [POLL_W-1:0]  poll_q;
  logic [15:0]        wdog_q;
`endif

  function automatic logic [31:0] reg_adr(input logic [3:0] idx);
    return BASE_ADDR + 32'({idx, 2'b00});
  endfunction

  // {we, adr, dat} for the transfer issued in state s, beat b
  function automatic logic [64:0] bus_req(input state_e s, input logic [1:0] b);
    logic [64:0] r;
    r = '0;
    case (s)
      S_CLR:   r = {1'b1, reg_adr(4'd0), 32'h0};
      S_ENA:   r = {1'b1, reg_adr(4'd0), 32'h1};
      S_WKEY:  r = {1'b1, reg_adr(4'd1 + 4'(b)), key_q[{b, 5'b0} +: 32]};
      S_WTXT:  r = {1'b1, reg_adr(4'd5 + 4'(b)), text_q[{b, 5'b0} +: 32]};
      S_LOAD:  r = {1'b1, reg_adr(4'd0), 32'h3};
      S_RUN:   r = {1'b1, reg_adr(4'd0), 32'h1};
      S_POLL:  r = {1'b0, reg_adr(4'd0), 32'h0};
      S_RD:    r = {1'b0, reg_adr(4'd5 + 4'(b)), 32'h0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Successor taken once the post-ack idle cycle has elapsed
  always_comb begin
    nxt_state_d = state_q;
    nxt_beat_d  = beat_q + 2'd1;
    case (state_q)
      S_CLR:   nxt_state_d = S_ENA;
      S_ENA:   nxt_state_d = S_WKEY;
      S_WKEY:  if (beat_q == 2'd3) nxt_state_d = S_WTXT;
      S_WTXT:  if (beat_q == 2'd3) nxt_state_d = S_LOAD;
      S_LOAD:  nxt_state_d = S_RUN;
      S_RUN:   nxt_state_d = S_POLL;
      S_POLL:  nxt_state_d = S_RD;
      S_RD:    if (beat_q == 2'd3) nxt_state_d = S_DONE;
      default: nxt_state_d = state_q;
    endcase
    if (nxt_state_d != state_q) nxt_beat_d = 2'd0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      gap_q    <= '0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      key_q    <= '0;
      text_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef AES_WB_MASTER_TIMEOUT_EN
      error_q  <= 1'b0;
      poll_q   <= '0;
      wdog_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            key_q   <= key_i;
            text_q  <= text_i;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CLR;
            beat_q  <= '0;
            stb_q   <= 1'b1;
            {we_q, adr_q, dat_q} <= bus_req(S_CLR, 2'd0);
`ifdef AES_WB_MASTER_TIMEOUT_EN
            error_q <= 1'b0;
            poll_q  <= '0;
            wdog_q  <= '0;
`endif
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_POLL;
            beat_q  <= '0;
            stb_q   <= 1'b1;
            {we_q, adr_q, dat_q} <= bus_req(S_POLL, 2'd0);
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: begin
          if (stb_q) begin
            if (wbm.wbm_ack_i) begin
              stb_q <= 1'b0;
`ifdef AES_WB_MASTER_TIMEOUT_EN
              wdog_q <= '0;
`endif
              if (state_q == S_RD) result_q[{beat_q, 5'b0} +: 32] <= wbm.wbm_dat_i;
              // Not done yet: go straight to GAP so the idle run is exactly POLL_GAP cycles
              if (state_q == S_POLL && !wbm.wbm_dat_i[2]) begin
                beat_q <= '0;
`ifdef AES_WB_MASTER_TIMEOUT_EN
                if (poll_q == POLL_LAST) begin
                  state_q <= S_ERR;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                end else begin
                  poll_q  <= poll_q + POLL_W'(1);
                  state_q <= S_GAP;
                  gap_q   <= '0;
                end
`else
                state_q <= S_GAP;
                gap_q   <= '0;
`endif
              end
            end else begin
`ifdef AES_WB_MASTER_TIMEOUT_EN
              if (wdog_q == WDOG_LAST) begin
                stb_q   <= 1'b0;
                state_q <= S_ERR;
                error_q <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                wdog_q <= wdog_q + 16'd1;
              end
`endif
            end
          end else begin
            state_q <= nxt_state_d;
            beat_q  <= nxt_beat_d;
            if (nxt_state_d == S_DONE) begin
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stb_q <= 1'b1;
              {we_q, adr_q, dat_q} <= bus_req(nxt_state_d, nxt_beat_d);
            end
          end
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
`ifdef AES_WB_MASTER_TIMEOUT_EN
  assign error_o        = error_q;
`endif
  assign wbm.wbm_cyc_o  = stb_q;
  assign wbm.wbm_stb_o  = stb_q;
  assign wbm.wbm_we_o   = we_q;
  assign wbm.wbm_sel_o  = {4{stb_q}};
  assign wbm.wbm_adr_o  = adr_q;
  assign wbm.wbm_dat_o  = dat_q;

endmodule

// File: tb/tb_aes_wb_master.sv
// Directed bench for aes_wb_master against a register-level model of the AES128 Wishbone peripheral.
module tb_aes_wb_master;

  localparam logic [31:0]  BASE = 32'h3000_0000;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TXT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] TXT1 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk, rst, start;
  logic [127:0] key, text, result;
  logic         busy, valid;
`ifdef AES_WB_MASTER_TIMEOUT_EN
  logic         error;
`endif

  int tests_run, tests_failed;

  aes_wb_master_if wbm();

  aes_wb_master #(
    .BASE_ADDR(BASE),
    .POLL_GAP (4)
`ifdef AES_WB_MASTER_TIMEOUT_EN
    , .MAX_POLLS(8)
`endif
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .start_i       (start),
    .key_i         (key),
    .text_i        (text),
    .busy_o        (busy),
    .result_o      (result),
    .result_valid_o(valid),
`ifdef AES_WB_MASTER_TIMEOUT_EN
    .error_o       (error),
`endif
    .wbm           (wbm)
  );

  always #5 clk = ~clk;

  // Peripheral model: registered ack after wait_states extra cycles, CTRL done after done_after polls
  int wait_states, done_after, polls_seen, wcnt;
  logic [127:0] ct_word_src;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wbm.wbm_ack_i <= 1'b0;
      wbm.wbm_dat_i <= '0;
      wcnt = 0;
    end else begin
      wbm.wbm_ack_i <= 1'b0;
      if (wbm.wbm_stb_o && !wbm.wbm_ack_i) begin
        if (wcnt >= wait_states) begin
          wcnt = 0;
          wbm.wbm_ack_i <= 1'b1;
          wbm.wbm_dat_i <= 32'h0;
          if (!wbm.wbm_we_o) begin
            if (wbm.wbm_adr_o == BASE) begin
              wbm.wbm_dat_i <= {29'd0, (polls_seen >= done_after), 2'b01};
              polls_seen++;
            end else if (wbm.wbm_adr_o >= BASE + 32'h14 && wbm.wbm_adr_o <= BASE + 32'h20) begin
              ct_word_src = CT0;
              wbm.wbm_dat_i <= ct_word_src[32*(((wbm.wbm_adr_o - BASE) >> 2) - 5) +: 32];
            end
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Bus monitor: protocol violation counters and a transfer trace
  int cyc_n, n_xfer, n_ctrl_rd, sel_bad, cs_bad, gap_bad, hold_bad;
  bit in_xfer, prev_ack;
  logic [31:0] h_adr, h_dat;
  logic        h_we;
  logic [31:0] tr_adr[$], tr_dat[$];
  logic        tr_we[$];
  int          ctrl_start[$], ctrl_ack[$];
  always @(posedge clk) begin
    cyc_n++;
    if (rst) begin
      in_xfer  = 0;
      prev_ack = 0;
    end else begin
      if (wbm.wbm_cyc_o !== wbm.wbm_stb_o) cs_bad++;
      if (wbm.wbm_sel_o !== (wbm.wbm_stb_o ? 4'hF : 4'h0)) sel_bad++;
      if (prev_ack && wbm.wbm_cyc_o) gap_bad++;
      if (wbm.wbm_stb_o) begin
        if (!in_xfer) begin
          in_xfer = 1;
          h_adr = wbm.wbm_adr_o;
          h_dat = wbm.wbm_dat_o;
          h_we  = wbm.wbm_we_o;
          if (!h_we && h_adr == BASE) ctrl_start.push_back(cyc_n);
        end else if (h_adr !== wbm.wbm_adr_o || h_dat !== wbm.wbm_dat_o || h_we !== wbm.wbm_we_o) begin
          hold_bad++;
        end
        if (wbm.wbm_ack_i) begin
          in_xfer = 0;
          n_xfer++;
          tr_adr.push_back(h_adr);
          tr_dat.push_back(h_dat);
          tr_we.push_back(h_we);
          if (!h_we && h_adr == BASE) begin
            n_ctrl_rd++;
            ctrl_ack.push_back(cyc_n);
          end
        end
      end
      prev_ack = wbm.wbm_stb_o && wbm.wbm_ack_i;
    end
  end

  task automatic clear_mon();
    n_xfer = 0; n_ctrl_rd = 0; sel_bad = 0; cs_bad = 0; gap_bad = 0; hold_bad = 0;
    tr_adr.delete(); tr_dat.delete(); tr_we.delete();
    ctrl_start.delete(); ctrl_ack.delete();
  endtask

  task automatic pulse_start(input logic [127:0] k, input logic [127:0] t);
    @(negedge clk);
    key = k; text = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
`ifdef AES_WB_MASTER_TIMEOUT_EN
      if (valid || error) begin ok = 1; break; end
`else
      if (valid) begin ok = 1; break; end
`endif
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests_run++; if (result !== 128'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", result); end
    tests_run++; if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o, wbm.wbm_sel_o} !== 7'h0) begin
      tests_failed++; $display("FAIL reset_ctl: got %b want 0", {wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o, wbm.wbm_sel_o}); end
    tests_run++; if ({wbm.wbm_adr_o, wbm.wbm_dat_o} !== 64'h0) begin
      tests_failed++; $display("FAIL reset_adr_dat: got %h want 0", {wbm.wbm_adr_o, wbm.wbm_dat_o}); end
`ifdef AES_WB_MASTER_TIMEOUT_EN
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b want 0", error); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips();
    bit ok;
    logic [64:0] exp_tr[12];
    exp_tr = '{ {1'b1, BASE,          32'h0},        {1'b1, BASE,          32'h1},
                {1'b1, BASE + 32'h04, 32'h0c0d0e0f}, {1'b1, BASE + 32'h08, 32'h08090a0b},
                {1'b1, BASE + 32'h0C, 32'h04050607}, {1'b1, BASE + 32'h10, 32'h00010203},
                {1'b1, BASE + 32'h14, 32'hccddeeff}, {1'b1, BASE + 32'h18, 32'h8899aabb},
                {1'b1, BASE + 32'h1C, 32'h44556677}, {1'b1, BASE + 32'h20, 32'h00112233},
                {1'b1, BASE,          32'h3},        {1'b1, BASE,          32'h1} };
    wait_states = 0; done_after = 0; polls_seen = 0;
    clear_mon();
    pulse_start(KEY0, TXT0);
    wait_end(2000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL fips_timeout: no result_valid within budget"); end
    tests_run++; if (result !== CT0) begin tests_failed++; $display("FAIL fips_result: got %h want %h", result, CT0); end
    tests_run++; if ({valid, busy} !== 2'b10) begin tests_failed++; $display("FAIL fips_flags: got valid/busy %b want 10", {valid, busy}); end
    tests_run++; if (n_xfer !== 17) begin tests_failed++; $display("FAIL fips_xfer_count: got %0d want 17", n_xfer); end
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if ({tr_we[i], tr_adr[i], tr_dat[i]} !== exp_tr[i]) begin
        tests_failed++; $display("FAIL fips_trace[%0d]: got %h want %h", i, {tr_we[i], tr_adr[i], tr_dat[i]}, exp_tr[i]);
      end
    end
    tests_run++; if ({tr_we[12], tr_adr[12]} !== {1'b0, BASE}) begin
      tests_failed++; $display("FAIL fips_poll_adr: got %h want %h", {tr_we[12], tr_adr[12]}, {1'b0, BASE}); end
    tests_run++; if ({tr_we[13], tr_adr[13], tr_adr[16]} !== {1'b0, BASE + 32'h14, BASE + 32'h20}) begin
      tests_failed++; $display("FAIL fips_read_adr: got %h want %h", {tr_we[13], tr_adr[13], tr_adr[16]}, {1'b0, BASE + 32'h14, BASE + 32'h20}); end
    tests_run++; if ({sel_bad, cs_bad, gap_bad} !== 96'h0) begin
      tests_failed++; $display("FAIL fips_protocol: sel/cyc-stb/gap errors %0d/%0d/%0d want 0", sel_bad, cs_bad, gap_bad); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    polls_seen = 0;
    pulse_start(KEY1, TXT1);
    tests_run++; if ({valid, busy} !== 2'b01) begin tests_failed++; $display("FAIL b2b_accept: got valid/busy %b want 01", {valid, busy}); end
    wait_end(2000, ok);
    tests_run++; if (!ok || valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_done: ok=%0d valid=%b want valid 1", ok, valid); end
    tests_run++; if ({tr_dat[2], tr_dat[5], tr_dat[6]} !== {32'h09cf4f3c, 32'h2b7e1516, 32'he0370734}) begin
      tests_failed++; $display("FAIL b2b_words: got %h want %h", {tr_dat[2], tr_dat[5], tr_dat[6]}, {32'h09cf4f3c, 32'h2b7e1516, 32'he0370734}); end
  endtask

  task automatic test_wait_states();
    bit ok;
    wait_states = 5; done_after = 0; polls_seen = 0;
    clear_mon();
    pulse_start(KEY0, TXT0);
    wait_end(4000, ok);
    tests_run++; if (!ok || result !== CT0) begin tests_failed++; $display("FAIL ws_result: ok=%0d got %h want %h", ok, result, CT0); end
    tests_run++; if (hold_bad !== 0) begin tests_failed++; $display("FAIL ws_hold: %0d unstable wait cycles want 0", hold_bad); end
    tests_run++; if (n_xfer !== 17 || gap_bad !== 0) begin tests_failed++; $display("FAIL ws_xfers: got %0d xfers %0d gap errors want 17/0", n_xfer, gap_bad); end
    wait_states = 0;
  endtask

  task automatic test_polling();
    bit ok;
    done_after = 3; polls_seen = 0;
    clear_mon();
    pulse_start(KEY0, TXT0);
    for (int i = 0; i < 1000 && polls_seen < 2; i++) @(negedge clk);
    pulse_start(KEY1, TXT1);
    wait_end(2000, ok);
    tests_run++; if (!ok || result !== CT0) begin tests_failed++; $display("FAIL poll_result: ok=%0d got %h want %h", ok, result, CT0); end
    tests_run++; if (n_ctrl_rd !== 4) begin tests_failed++; $display("FAIL poll_reads: got %0d want 4", n_ctrl_rd); end
    tests_run++; if (n_xfer !== 20 || tr_dat[2] !== 32'h0c0d0e0f) begin
      tests_failed++; $display("FAIL poll_start_ignored: got %0d xfers key0 %h want 20 / 0c0d0e0f", n_xfer, tr_dat[2]); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ctrl_start[i+1] - ctrl_ack[i] - 1 !== 4) begin
        tests_failed++; $display("FAIL poll_gap[%0d]: got %0d idle cycles want 4", i, ctrl_start[i+1] - ctrl_ack[i] - 1);
      end
    end
    done_after = 0;
  endtask

  task automatic test_mid_reset();
    bit ok, hit;
    polls_seen = 0;
    clear_mon();
    pulse_start(KEY0, TXT0);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      if (wbm.wbm_stb_o && wbm.wbm_we_o && wbm.wbm_adr_o == BASE + 32'h1C) begin hit = 1; break; end
      @(negedge clk);
    end
    tests_run++; if (!hit) begin tests_failed++; $display("FAIL mrst_reach: WTXT beat 2 not seen"); end
    rst = 1'b1;
    #1;
    tests_run++; if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, busy} !== 3'b000) begin
      tests_failed++; $display("FAIL mrst_drop: got cyc/stb/busy %b want 000", {wbm.wbm_cyc_o, wbm.wbm_stb_o, busy}); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    polls_seen = 0;
    clear_mon();
    pulse_start(KEY0, TXT0);
    wait_end(2000, ok);
    tests_run++; if ({tr_we[0], tr_adr[0], tr_dat[0]} !== {1'b1, BASE, 32'h0}) begin
      tests_failed++; $display("FAIL mrst_restart: got %h want %h", {tr_we[0], tr_adr[0], tr_dat[0]}, {1'b1, BASE, 32'h0}); end
    tests_run++; if (!ok || result !== CT0 || n_xfer !== 17) begin
      tests_failed++; $display("FAIL mrst_result: ok=%0d xfers=%0d got %h want %h", ok, n_xfer, result, CT0); end
  endtask

`ifdef AES_WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    done_after = 1000; polls_seen = 0;
    clear_mon();
    pulse_start(KEY0, TXT0);
    wait_end(3000, ok);
    tests_run++; if (!ok || error !== 1'b1) begin tests_failed++; $display("FAIL to_error: ok=%0d error=%b want 1", ok, error); end
    tests_run++; if (n_ctrl_rd !== 8) begin tests_failed++; $display("FAIL to_reads: got %0d want 8", n_ctrl_rd); end
    tests_run++; if ({busy, valid} !== 2'b00) begin tests_failed++; $display("FAIL to_flags: got busy/valid %b want 00", {busy, valid}); end
    done_after = 0; polls_seen = 0;
    pulse_start(KEY0, TXT0);
    tests_run++; if ({error, busy} !== 2'b01) begin tests_failed++; $display("FAIL to_clear: got error/busy %b want 01", {error, busy}); end
    wait_end(2000, ok);
    tests_run++; if (!ok || valid !== 1'b1 || result !== CT0) begin tests_failed++; $display("FAIL to_recover: valid=%b got %h", valid, result); end
  endtask
`endif

  initial begin
    clk = 1'b0; rst = 1'b0; start = 1'b0; key = '0; text = '0;
    wait_states = 0; done_after = 0; polls_seen = 0;
    tests_run = 0; tests_failed = 0;
    clear_mon();
    test_reset();
    test_fips();
    test_back_to_back();
    test_wait_states();
    test_polling();
    test_mid_reset();
`ifdef AES_WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
